// File: rtl/keypad_pkg.sv
// Shared keypad definitions: matrix geometry, scanner states and legend map.
package keypad_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } scan_state_t;

  // Map a row*4+col key code to the printed keypad legend for display.
  // The '*' key shows as E and '#' as F.
  function automatic logic [3:0] key_to_hex(input logic [3:0] code);
    logic [3:0] hex;
    case (code)
      4'd0:    hex = 4'h1;
      4'd1:    hex = 4'h2;
      4'd2:    hex = 4'h3;
      4'd3:    hex = 4'hA;
      4'd4:    hex = 4'h4;
      4'd5:    hex = 4'h5;
      4'd6:    hex = 4'h6;
      4'd7:    hex = 4'hB;
      4'd8:    hex = 4'h7;
      4'd9:    hex = 4'h8;
      4'd10:   hex = 4'h9;
      4'd11:   hex = 4'hC;
      4'd12:   hex = 4'hE;
      4'd13:   hex = 4'h0;
      4'd14:   hex = 4'hF;
      default: hex = 4'hD;
    endcase
    return hex;
  endfunction

endpackage

// File: rtl/keypad_scanner_input_sync.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all ones
// so idle pulled-up lines read as inactive straight out of reset.
module input_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture chain; the first stage may go metastable.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      // NOTE: non-blocking assignments let both stages sample the old values
      // on the same edge, forming a real shift chain regardless of order.
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column, debounces a single
// key on press and release, and hands the key code to a valid/ack register.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clock,
  input  logic                rst,
  input  logic [KEY_ROWS-1:0] row_in,
  output logic [KEY_COLS-1:0] col_out,
  output logic [3:0]          key_code,
  output logic                key_valid,
  input  logic                key_ack,
  output logic                key_down,
  output logic                key_overrun
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_SCANS - 1);

  logic [KEY_ROWS-1:0] rows_s;

  input_sync #(.WIDTH(KEY_ROWS)) u_row_sync (
    .clock (clock),
    .rst   (rst),
    .d     (row_in),
    .q     (rows_s)
  );

  scan_state_t         state_q,       state_d;
  logic [CW-1:0]       cnt_q,         cnt_d;
  logic [1:0]          col_q,         col_d;
  logic [1:0]          row_q,         row_d;
  logic [DW-1:0]       deb_q,         deb_d;
  logic [KEY_COLS-1:0] col_out_q,     col_out_d;
  logic [3:0]          key_code_q,    key_code_d;
  logic                key_valid_q,   key_valid_d;
  logic                key_down_q,    key_down_d;
  logic                key_overrun_q, key_overrun_d;

  logic dwell_end;
  logic any_low;
  logic accept;
  logic advance;

  assign dwell_end = (cnt_q == DWELL_LAST);
  assign any_low   = ~&rows_s;

  // Next-state logic for the dwell timer, scan FSM, debounce and key register.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d       = state_q;
    cnt_d         = dwell_end ? '0 : cnt_q + CW'(1);
    col_d         = col_q;
    row_d         = row_q;
    deb_d         = deb_q;
    key_code_d    = key_code_q;
    key_valid_d   = key_valid_q;
    key_down_d    = key_down_q;
    key_overrun_d = key_overrun_q;
    accept        = 1'b0;
    advance       = 1'b0;

    // Acknowledge only matters while a key is pending.
    if (key_ack && key_valid_q) begin
      key_valid_d   = 1'b0;
      key_overrun_d = 1'b0;
    end

    if (dwell_end) begin
      case (state_q)
        SCAN: begin
          if (any_low) begin
            // Lowest-index low row wins when several are down.
            if (!rows_s[0])      row_d = 2'd0;
            else if (!rows_s[1]) row_d = 2'd1;
            else if (!rows_s[2]) row_d = 2'd2;
            else                 row_d = 2'd3;
            if (DEBOUNCE_SCANS == 1) begin
              accept = 1'b1;
            end else begin
              state_d = DEBOUNCE;
              deb_d   = DW'(1);
            end
          end else begin
            advance = 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!rows_s[row_q]) begin
            if (deb_q == DEB_LAST) accept = 1'b1;
            else                   deb_d  = deb_q + DW'(1);
          end else begin
            state_d = SCAN;
            advance = 1'b1;
          end
        end
        HELD: begin
          if (rows_s[row_q]) begin
            if (deb_q == DEB_LAST) begin
              key_down_d = 1'b0;
              state_d    = SCAN;
              advance    = 1'b1;
            end else begin
              deb_d = deb_q + DW'(1);
            end
          end else begin
            deb_d = '0;
          end
        end
        default: begin
          state_d = SCAN;
        end
      endcase
    end

    // A new key always loads; it is an overrun only if the old one was
    // still pending and not being acknowledged this very cycle.
    if (accept) begin
      state_d     = HELD;
      deb_d       = '0;
      key_code_d  = {row_d, col_q};
      key_valid_d = 1'b1;
      key_down_d  = 1'b1;
      if (key_valid_q && !key_ack) key_overrun_d = 1'b1;
    end

    if (advance) col_d = col_q + 2'd1;

    col_out_d = ~(KEY_COLS'(1) << col_d);
  end

  // Single state register for the whole scanner, outputs included.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q       <= SCAN;
      cnt_q         <= '0;
      col_q         <= 2'd0;
      row_q         <= 2'd0;
      deb_q         <= '0;
      col_out_q     <= 4'b1110;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_down_q    <= 1'b0;
      key_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      col_q         <= col_d;
      row_q         <= row_d;
      deb_q         <= deb_d;
      col_out_q     <= col_out_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_down_q    <= key_down_d;
      key_overrun_q <= key_overrun_d;
    end
  end

  assign col_out     = col_out_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_down    = key_down_q;
  assign key_overrun = key_overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// k counts rising edges since reset release; samples are taken on the
// falling edge after edge k. Dwell ends fall on edges k = 4, 8, 12, ...
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       key_down;
  logic       key_overrun;

  // Simulated key: pulls row key_r low while column key_c is driven.
  logic       press = 1'b0;
  logic [1:0] key_r = 2'd0;
  logic [1:0] key_c = 2'd0;

  int checks = 0;
  int errors = 0;
  int k      = 0;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .row_in      (row_in),
    .col_out     (col_out),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ack     (key_ack),
    .key_down    (key_down),
    .key_overrun (key_overrun)
  );

  always #5 clock = ~clock;

  always_comb begin
    row_in = 4'hF;
    if (press && (col_out[key_c] == 1'b0)) row_in = ~(4'b0001 << key_r);
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance to the falling edge that follows rising edge number target.
  task automatic adv(input int target);
    while (k < target) begin
      @(negedge clock);
      k++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".col"},     col_out,            4'b1110);
    check({tag, ".code"},    key_code,           4'd0);
    check({tag, ".valid"},   4'(key_valid),      4'd0);
    check({tag, ".down"},    4'(key_down),       4'd0);
    check({tag, ".overrun"}, 4'(key_overrun),    4'd0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    rst = 1'b0;
    k   = 0;

    // Idle scan: four edges per column, wrapping back to column 0.
    for (int i = 1; i <= 16; i++) begin
      adv(i);
      check("idle.col", col_out, ~(4'b0001 << ((i / 4) % 4)));
      if (i == 16) begin
        check("idle.valid", 4'(key_valid), 4'd0);
        check("idle.down",  4'(key_down),  4'd0);
      end
    end

    // Key row 2 / col 1: detected at edge 24, accepted at edge 32.
    key_r = 2'd2; key_c = 2'd1; press = 1'b1;
    adv(28);
    check("deb.col_hold", col_out, 4'b1101);
    check("deb.valid",    4'(key_valid), 4'd0);
    adv(31);
    check("acc.early",    4'(key_valid), 4'd0);
    adv(32);
    check("acc.valid",    4'(key_valid), 4'd1);
    check("acc.code",     key_code,      4'd9);
    check("acc.down",     4'(key_down),  4'd1);
    check("acc.col",      col_out,       4'b1101);
    check("acc.legend",   key_to_hex(key_code), 4'h8);
    key_ack = 1'b1;
    adv(33);
    key_ack = 1'b0;
    check("ack.valid",    4'(key_valid), 4'd0);
    check("ack.down",     4'(key_down),  4'd1);

    // Release with a glitch: high at 36,40; low at 44; high at 48,52,56.
    press = 1'b0;
    key_ack = 1'b1;                     // ack with nothing pending is ignored
    adv(34);
    key_ack = 1'b0;
    check("ack_idle.valid",   4'(key_valid),   4'd0);
    check("ack_idle.overrun", 4'(key_overrun), 4'd0);
    adv(41);
    press = 1'b1;
    adv(45);
    press = 1'b0;
    adv(48);
    check("rel.glitch_down", 4'(key_down), 4'd1);
    adv(55);
    check("rel.pre_down",    4'(key_down), 4'd1);
    check("rel.pre_col",     col_out,      4'b1101);
    adv(56);
    check("rel.down",        4'(key_down), 4'd0);
    check("rel.col",         col_out,      4'b1011);

    // Bounce on row 2 / col 1: low at edge 72 only, high at edge 76.
    press = 1'b1;
    adv(73);
    press = 1'b0;
    check("bnc.col_hold", col_out, 4'b1101);
    adv(76);
    check("bnc.col",      col_out,       4'b1011);
    check("bnc.valid",    4'(key_valid), 4'd0);
    check("bnc.down",     4'(key_down),  4'd0);

    // First key row 1 / col 0, accepted at edge 96 and left unacknowledged.
    key_r = 2'd1; key_c = 2'd0; press = 1'b1;
    adv(96);
    check("k1.valid",   4'(key_valid),   4'd1);
    check("k1.code",    key_code,        4'd4);
    check("k1.overrun", 4'(key_overrun), 4'd0);
    press = 1'b0;
    adv(108);
    check("k1.rel_down", 4'(key_down), 4'd0);
    check("k1.rel_col",  col_out,      4'b1101);

    // Second key row 0 / col 3, accepted at edge 128 over the pending one.
    key_r = 2'd0; key_c = 2'd3; press = 1'b1;
    adv(127);
    check("k2.early_overrun", 4'(key_overrun), 4'd0);
    adv(128);
    check("k2.valid",   4'(key_valid),   4'd1);
    check("k2.code",    key_code,        4'd3);
    check("k2.overrun", 4'(key_overrun), 4'd1);
    check("k2.legend",  key_to_hex(key_code), 4'hA);
    key_ack = 1'b1;
    adv(129);
    key_ack = 1'b0;
    check("k2.ack_valid",   4'(key_valid),   4'd0);
    check("k2.ack_overrun", 4'(key_overrun), 4'd0);

    // Release at edge 140 (col back to 0), then row 1 / col 0 accepted at 152.
    press = 1'b0;
    adv(140);
    check("k2.rel_col", col_out, 4'b1110);
    key_r = 2'd1; key_c = 2'd0; press = 1'b1;
    adv(152);
    check("k3.valid", 4'(key_valid), 4'd1);
    check("k3.down",  4'(key_down),  4'd1);

    // Asynchronous reset while HELD with a pending key.
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_held");
    press = 1'b0;
    repeat (2) @(negedge clock);
    rst = 1'b0;
    repeat (3) @(negedge clock);
    check("post_rst.valid", 4'(key_valid), 4'd0);
    check("post_rst.col",   col_out,       4'b1110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
